bsg_counter_set_down_ctrl: RTL and testbench
============================================

Name: bsg_counter_set_down_ctrl

Overview:
- Control stage directly upstream of bsg_counter_set_down; it drives the counter's set_i/val_i/down_i and reads back count_r_o.
- Accepts timer-load requests over a valid/ready handshake and decrements the counter once per qualifying tick.
- Reports completion (reached zero or aborted) over a valid/yumi handshake.
- Holds one pending load so back-to-back timers incur no idle cycle beyond the completion handshake.

Parameters:
width_p, 32, width of load value, val_o and count_i

Ports:
clk_i  in  1  clock
reset_i  in  1  reset; one clock; reset is synchronous and active-high
v_i  in  1  load request valid
val_i  in  width_p  load value
ready_o  out  1  load request accepted when v_i & ready_o
tick_i  in  1  decrement qualifier
abort_i  in  1  cancel the running timer
count_i  in  width_p  counter value (count_r_o of the counter)
set_o  out  1  to counter set_i
val_o  out  width_p  to counter val_i
down_o  out  1  to counter down_i
busy_o  out  1  state != IDLE
done_v_o  out  1  completion valid
done_aborted_o  out  1  qualifies done_v_o: 1 = aborted, 0 = reached zero
done_yumi_i  in  1  completion consumed; legal only while done_v_o

Behaviour:
- State: IDLE, RUN, DONE. Registers: state_r, pend_v_r, pend_r[width_p], aborted_r.
- Counter timing:
  - set_o in cycle T -> count_i == val_o in T+1.
  - down_o in T -> count_i decrements in T+1.
- set_o, val_o, down_o, ready_o are combinational.
- Default outputs: val_o = 0 when set_o = 0.
- Reset (reset_i high): state_r = IDLE, pend_v_r = 0, aborted_r = 0. While reset_i is high: ready_o = set_o = down_o = done_v_o = busy_o = 0.
- IDLE:
  - ready_o = 1.
  - On v_i: set_o = 1, val_o = val_i.
  - Next state: DONE with aborted_r = 0 if val_i == 0, else RUN.
- RUN:
  - down_o = tick_i & ~abort_i & (count_i != 0).
  - down_o & count_i == 1 -> DONE, aborted_r = 0.
  - count_i == 0 (defensive) -> DONE, aborted_r = 0.
  - abort_i -> set_o = 1, val_o = 0, down_o = 0; next DONE, aborted_r = 1. Abort beats tick.
  - ready_o = ~pend_v_r. An accepted request is written to pend_r and pend_v_r is set.
- DONE:
  - done_v_o = 1, done_aborted_o = aborted_r. tick_i and abort_i are ignored.
  - ready_o = ~pend_v_r.
  - On done_yumi_i, the load source is pend_r if pend_v_r, else val_i if v_i (direct accept), else none.
    - Source present: set_o = 1, val_o = source, clear pend_v_r; next RUN, or DONE (aborted_r = 0) if source == 0.
    - No source: next IDLE.
  - Without done_yumi_i, an accepted v_i fills the pending slot.
- Pending slot depth is 1. abort_i does not clear the pending slot.
- A value of 0 completes with no RUN cycle. A value of 1 needs one tick.
- Counter wrap-around is impossible: down_o is never asserted while count_i == 0.
- Reset mid-operation discards the running timer, the pending load and the undelivered completion.

Test Plan:
- Reset, then v_i with val_i = 3 and tick_i = 1 held:
  - set_o = 1 and val_o = 3 in cycle 0.
  - down_o in cycles 1, 2, 3; count 3 -> 2 -> 1 -> 0.
  - done_v_o = 1 and done_aborted_o = 0 from cycle 4.
  - done_yumi_i returns the block to IDLE.
- Load 5 with tick_i toggling 1,0,1,0...: down_o only on tick cycles; done_v_o follows the 5th tick.
- Load 0: next cycle is DONE (done_v_o = 1, done_aborted_o = 0) with down_o never asserted.
- Load 10, abort_i and tick_i both asserted after 2 ticks:
  - set_o = 1, val_o = 0, down_o = 0.
  - done_aborted_o = 1 next cycle; count_i = 0.
- Load 4, then v_i = 7 while in RUN:
  - Accepted; ready_o drops.
  - A third request is stalled until completion.
  - On yumi, set_o = 1 and val_o = 7 in the same cycle; RUN resumes with no IDLE cycle.
- Assert reset_i while in RUN with the pending slot full:
  - Next cycle: IDLE, ready_o = 1, no done_v_o.
  - The pending value is never loaded.

Source files
------------

// File: rtl/bsg_counter_set_down_ctrl.sv
// Control stage for bsg_counter_set_down: loads timers over valid/ready, counts them
// down on qualifying ticks, and reports completion (zero or abort) over valid/yumi.
module bsg_counter_set_down_ctrl #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] val_i,
  output logic               ready_o,
  input  logic               tick_i,
  input  logic               abort_i,
  input  logic [width_p-1:0] count_i,
  output logic               set_o,
  output logic [width_p-1:0] val_o,
  output logic               down_o,
  output logic               busy_o,
  output logic               done_v_o,
  output logic               done_aborted_o,
  input  logic               done_yumi_i
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [width_p-1:0] one_lp = {{(width_p-1){1'b0}}, 1'b1};

  state_e             state_r, state_n;
  logic               pend_v_r, pend_v_n;
  logic [width_p-1:0] pend_r;
  logic               pend_we;
  logic               aborted_r, aborted_n;
  logic               src_v;
  logic [width_p-1:0] src_val;

  always_comb begin
    state_n        = state_r;
    pend_v_n       = pend_v_r;
    pend_we        = 1'b0;
    aborted_n      = aborted_r;
    src_v          = 1'b0;
    src_val        = '0;
    ready_o        = 1'b0;
    set_o          = 1'b0;
    val_o          = '0;
    down_o         = 1'b0;
    busy_o         = 1'b0;
    done_v_o       = 1'b0;
    done_aborted_o = 1'b0;

    if (!reset_i) begin
      busy_o = (state_r != IDLE);
      unique case (state_r)
        IDLE: begin
          ready_o = 1'b1;
          if (v_i) begin
            set_o = 1'b1;
            val_o = val_i;
            if (val_i == '0) begin
              state_n   = DONE;
              aborted_n = 1'b0;
            end else begin
              state_n = RUN;
            end
          end
        end

        RUN: begin
          ready_o = ~pend_v_r;
          if (v_i && !pend_v_r) begin
            pend_we  = 1'b1;
            pend_v_n = 1'b1;
          end
          // Abort wins over tick: force the counter to zero instead of decrementing.
          if (abort_i) begin
            set_o     = 1'b1;
            val_o     = '0;
            state_n   = DONE;
            aborted_n = 1'b1;
          end else if (count_i == '0) begin
            state_n   = DONE;
            aborted_n = 1'b0;
          end else begin
            down_o = tick_i;
            if (tick_i && (count_i == one_lp)) begin
              state_n   = DONE;
              aborted_n = 1'b0;
            end
          end
        end

        DONE: begin
          done_v_o       = 1'b1;
          done_aborted_o = aborted_r;
          ready_o        = ~pend_v_r;
          if (done_yumi_i) begin
            // The pending load takes precedence; otherwise a fresh request is taken directly.
            if (pend_v_r) begin
              src_v    = 1'b1;
              src_val  = pend_r;
              pend_v_n = 1'b0;
            end else if (v_i) begin
              src_v   = 1'b1;
              src_val = val_i;
            end
            if (src_v) begin
              set_o = 1'b1;
              val_o = src_val;
              if (src_val == '0) begin
                state_n   = DONE;
                aborted_n = 1'b0;
              end else begin
                state_n = RUN;
              end
            end else begin
              state_n = IDLE;
            end
          end else if (v_i && !pend_v_r) begin
            pend_we  = 1'b1;
            pend_v_n = 1'b1;
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= IDLE;
      pend_v_r  <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      pend_v_r  <= pend_v_n;
      aborted_r <= aborted_n;
    end
  end

  // Pending value is plain data; its validity is tracked by pend_v_r.
  always_ff @(posedge clk_i) begin
    if (pend_we) pend_r <= val_i;
  end

endmodule

// File: tb/tb_bsg_counter_set_down_ctrl.sv
// Randomized bench for bsg_counter_set_down_ctrl with a transaction-level timer model
// and a completion scoreboard drained by an independent monitor.
module tb_bsg_counter_set_down_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         v = 1'b0, tick = 1'b0, abort = 1'b0, yumi = 1'b0;
  logic [W-1:0] val = '0;
  logic [W-1:0] count = '0;
  logic         ready, set, down, busy, done_v, done_ab;
  logic [W-1:0] val_out;

  int total = 0;
  int bad   = 0;

  // Model: timer phase (idle / running / finished), remaining ticks, pending loads.
  bit           m_running = 0, m_finished = 0, m_abort = 0;
  logic [W-1:0] m_rem = '0;
  logic [W-1:0] pq[$];
  bit           exp_q[$];

  always #5 clk = ~clk;

  bsg_counter_set_down_ctrl #(.width_p(W)) dut (
    .clk_i(clk), .reset_i(rst), .v_i(v), .val_i(val), .ready_o(ready),
    .tick_i(tick), .abort_i(abort), .count_i(count), .set_o(set), .val_o(val_out),
    .down_o(down), .busy_o(busy), .done_v_o(done_v), .done_aborted_o(done_ab),
    .done_yumi_i(yumi)
  );

  // Behavioural counter that the controller drives.
  always @(posedge clk) begin
    if (set) count <= val_out;
    else if (down) count <= count - 1;
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_timer(input logic [W-1:0] x);
    if (x == 0) begin
      m_running = 0; m_finished = 1; m_abort = 0; exp_q.push_back(1'b0);
    end else begin
      m_running = 1; m_finished = 0; m_rem = x;
    end
  endtask

  task automatic step(input bit r, input bit vv, input logic [W-1:0] vl,
                      input bit tk, input bit ab, input bit ym);
    bit e_ready, e_set, e_down;
    logic [W-1:0] e_val;
    @(posedge clk);
    #1;
    rst = r; v = vv; val = vl; tick = tk; abort = ab; yumi = ym & m_finished;
    #2;
    e_ready = 0; e_set = 0; e_down = 0; e_val = '0;
    if (r) begin
      m_running = 0; m_finished = 0; m_abort = 0;
      pq.delete(); exp_q.delete();
      chk("rst_busy", busy, 0);
      chk("rst_done_v", done_v, 0);
    end else if (!m_running && !m_finished) begin
      e_ready = 1;
      if (vv) begin e_set = 1; e_val = vl; start_timer(vl); end
      chk("busy", busy, 0);
      chk("done_v", done_v, 0);
    end else if (m_running) begin
      chk("count", count, m_rem);
      chk("busy", busy, 1);
      chk("done_v", done_v, 0);
      e_ready = (pq.size() == 0);
      if (vv && e_ready) pq.push_back(vl);
      if (ab) begin
        e_set = 1; e_val = '0;
        m_running = 0; m_finished = 1; m_abort = 1; m_rem = '0; exp_q.push_back(1'b1);
      end else if (tk) begin
        e_down = 1;
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_running = 0; m_finished = 1; m_abort = 0; exp_q.push_back(1'b0);
        end
      end
    end else begin
      chk("busy", busy, 1);
      chk("done_v", done_v, 1);
      chk("done_aborted", done_ab, m_abort);
      e_ready = (pq.size() == 0);
      if (yumi) begin
        if (pq.size() != 0) begin
          e_set = 1; e_val = pq.pop_front(); start_timer(e_val);
        end else if (vv) begin
          e_set = 1; e_val = vl; start_timer(vl);
        end else begin
          m_finished = 0;
        end
      end else if (vv && e_ready) begin
        pq.push_back(vl);
      end
    end
    chk("ready", ready, e_ready);
    chk("set", set, e_set);
    chk("val_o", val_out, e_val);
    chk("down", down, e_down);
  endtask

  // Completion monitor: every consumed completion must match the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && done_v && yumi) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL completion: got aborted=%0d expected none pending", done_ab);
        end else begin
          bit e;
          e = exp_q.pop_front();
          if (done_ab !== e) begin
            bad++;
            $display("FAIL completion: got aborted=%0d expected %0d", done_ab, e);
          end
        end
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // Load 3 with tick held, then consume.
    step(0, 1, 3, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    // Load 5 with alternating tick.
    step(0, 1, 5, 0, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 0, 0, (i % 2) == 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    // Load 0.
    step(0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    // Load 10, two ticks, then abort together with tick.
    step(0, 1, 10, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    // Load 4, pend 7, third request stalled, yumi hands over to 7.
    step(0, 1, 4, 0, 0, 0);
    step(0, 1, 7, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 9, 1, 0, 0);
    step(0, 1, 9, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    // Reset in RUN with the pending slot full.
    step(0, 1, 2, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      logic [W-1:0] rv;
      rv = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 20)) : W'($urandom_range(0, 6));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, rv,
           $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 2) == 0);
    end
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
